// File: rtl/snes_pad_responder.sv
// Pad-side end of the SNES serial link: captures 12 buttons on latch and shifts them out
// active-low, LSB first. Define SNES_PAD_WATCHDOG_EN to abort frames whose serial clock stalls.
module snes_pad_responder #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned NUM_BITS    = 16
`ifdef SNES_PAD_WATCHDOG_EN
   ,
   parameter int unsigned WDOG_CYCLES = 4096
`endif
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic [11:0] buttons_i,
   input  logic        snes_latch_i,
   input  logic        snes_clk_i,
   output logic        ser_data_o,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        wdog_o
);

   localparam int unsigned      CNT_W    = $clog2(NUM_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e                 state_q;
   logic [SYNC_STAGES-1:0] latch_sync_q;
   logic [SYNC_STAGES-1:0] clk_sync_q;
   logic                   clk_prev_q;
   logic [NUM_BITS-1:0]    shreg_q;
   logic [CNT_W-1:0]       bit_cnt_q;

   logic                   latch_s;
   logic                   clk_rise;
   logic [NUM_BITS-1:0]    load_val;
   logic [NUM_BITS-1:0]    shift_val;
   logic [CNT_W-1:0]       bit_cnt_inc;

`ifdef SNES_PAD_WATCHDOG_EN
   localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
   logic [15:0] wdog_cnt_q;
   logic        wdog_pulse_q;
   assign wdog_o = wdog_pulse_q;
`else
   assign wdog_o = 1'b0;
`endif

   assign latch_s     = latch_sync_q[SYNC_STAGES-1];
   assign clk_rise    = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
   assign load_val    = {{(NUM_BITS-12){1'b1}}, ~buttons_i};
   assign shift_val   = {1'b1, shreg_q[NUM_BITS-1:1]};
   assign bit_cnt_inc = bit_cnt_q + 1'b1;

   // Serial clock idles high, so its synchronizer resets high to avoid a false edge.
   always_ff @(posedge clk_i or posedge reset) begin : sync
      if (reset) begin
         latch_sync_q <= '0;
         clk_sync_q   <= '1;
         clk_prev_q   <= 1'b1;
      end else begin
         latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], snes_latch_i};
         clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], snes_clk_i};
         clk_prev_q   <= clk_sync_q[SYNC_STAGES-1];
      end
   end

   always_ff @(posedge clk_i or posedge reset) begin : fsm
      if (reset) begin
         state_q      <= StIdle;
         shreg_q      <= '1;
         bit_cnt_q    <= '0;
         ser_data_o   <= 1'b1;
         busy_o       <= 1'b0;
         frame_done_o <= 1'b0;
`ifdef SNES_PAD_WATCHDOG_EN
         wdog_cnt_q   <= '0;
         wdog_pulse_q <= 1'b0;
`endif
      end else begin
         frame_done_o <= 1'b0;
`ifdef SNES_PAD_WATCHDOG_EN
         wdog_pulse_q <= 1'b0;
`endif
         // Latch overrides every state and swallows any coincident serial clock edge.
         if (latch_s) begin
            state_q    <= StLoad;
            shreg_q    <= load_val;
            bit_cnt_q  <= '0;
            ser_data_o <= load_val[0];
            busy_o     <= 1'b1;
`ifdef SNES_PAD_WATCHDOG_EN
            wdog_cnt_q <= '0;
`endif
         end else begin
            unique case (state_q)
               StLoad: begin
                  state_q   <= StShift;
                  bit_cnt_q <= '0;
               end
               StShift: begin
                  if (clk_rise) begin
                     shreg_q   <= shift_val;
                     bit_cnt_q <= bit_cnt_inc;
`ifdef SNES_PAD_WATCHDOG_EN
                     wdog_cnt_q <= '0;
`endif
                     if (bit_cnt_inc == LAST_CNT) begin
                        state_q      <= StDone;
                        frame_done_o <= 1'b1;
                        busy_o       <= 1'b0;
                        ser_data_o   <= 1'b0;
                     end else begin
                        ser_data_o <= shift_val[0];
                     end
                  end
`ifdef SNES_PAD_WATCHDOG_EN
                  else if (wdog_cnt_q == WDOG_LAST) begin
                     state_q      <= StIdle;
                     ser_data_o   <= 1'b1;
                     busy_o       <= 1'b0;
                     wdog_pulse_q <= 1'b1;
                  end else begin
                     wdog_cnt_q <= wdog_cnt_q + 1'b1;
                  end
`endif
               end
               default: ; // StIdle and StDone hold their registered outputs
            endcase
         end
      end
   end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: emulates the host latch/clock and reads frames back.
module tb_snes_pad_responder;

   logic        clk_i = 1'b0;
   logic        reset;
   logic [11:0] buttons;
   logic        snes_latch;
   logic        snes_clk;
   logic        ser_data_o;
   logic        busy_o;
   logic        frame_done_o;
   logic        wdog_o;

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int wdog_cnt = 0;

   always #5 clk_i = ~clk_i;

   snes_pad_responder #(
      .SYNC_STAGES(2),
      .NUM_BITS   (16)
`ifdef SNES_PAD_WATCHDOG_EN
      ,
      .WDOG_CYCLES(64)
`endif
   ) dut (
      .clk_i       (clk_i),
      .reset       (reset),
      .buttons_i   (buttons),
      .snes_latch_i(snes_latch),
      .snes_clk_i  (snes_clk),
      .ser_data_o  (ser_data_o),
      .busy_o      (busy_o),
      .frame_done_o(frame_done_o),
      .wdog_o      (wdog_o)
   );

   always @(negedge clk_i) begin
      if (frame_done_o) done_cnt++;
      if (wdog_o) wdog_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   // Host side: latch, then sample bit k before the k-th rising serial clock edge.
   task automatic read_frame(input int n_clk, input int chg_at, input logic [11:0] chg_val,
                             output logic [15:0] data);
      data       = '1;
      snes_clk   = 1'b1;
      snes_latch = 1'b1;
      cycles(8);
      snes_latch = 1'b0;
      cycles(6);
      for (int k = 0; k < n_clk; k++) begin
         data[k] = ser_data_o;
         if (k == chg_at) buttons = chg_val;
         snes_clk = 1'b0;
         cycles(6);
         snes_clk = 1'b1;
         cycles(6);
      end
   endtask

   logic [15:0] rd;
   int          d0;
   int          waited;

   initial begin
      reset      = 1'b1;
      buttons    = 12'h000;
      snes_latch = 1'b0;
      snes_clk   = 1'b1;
      cycles(1);
      check("rst_ser", 32'(ser_data_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_pulses", 32'({frame_done_o, wdog_o}), 32'd0);
      cycles(3);
      reset = 1'b0;
      cycles(4);
      check("idle_ser", 32'(ser_data_o), 32'd1);

      // Reset mid-SHIFT: Start pressed puts a 0 on bit 3 before the reset hits.
      buttons = 12'h008;
      read_frame(3, -1, 12'h000, rd);
      check("pre_rst_bits", 32'(rd[2:0]), 32'h7);
      check("pre_rst_ser", 32'(ser_data_o), 32'd0);
      check("pre_rst_busy", 32'(busy_o), 32'd1);
      #3 reset = 1'b1;
      #1;
      check("midrst_ser", 32'(ser_data_o), 32'd1);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_pulses", 32'({frame_done_o, wdog_o}), 32'd0);
      cycles(3);
      reset = 1'b0;
      cycles(10);
      check("post_rst_ser", 32'(ser_data_o), 32'd1);
      check("post_rst_busy", 32'(busy_o), 32'd0);

      // B only
      buttons = 12'h001;
      d0 = done_cnt;
      read_frame(16, -1, 12'h000, rd);
      check("b_frame", 32'(rd), 32'hFFFE);
      check("b_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("b_ser_after", 32'(ser_data_o), 32'd0);
      check("b_busy_after", 32'(busy_o), 32'd0);
      snes_clk = 1'b0; cycles(6); snes_clk = 1'b1; cycles(6);
      check("extra_clk_ser", 32'(ser_data_o), 32'd0);
      check("extra_clk_done", 32'(done_cnt - d0), 32'd1);

      // Mixed pattern
      buttons = 12'hA50;
      read_frame(16, -1, 12'h000, rd);
      check("a50_low12", 32'(rd[11:0]), 32'h5AF);
      check("a50_frame", 32'(rd), 32'hF5AF);

      // Re-latch after 5 clocks, with a serial clock edge coincident with the latch
      buttons = 12'h0F3;
      d0 = done_cnt;
      read_frame(5, -1, 12'h000, rd);
      check("part_bits", 32'(rd[4:0]), 32'h0C);
      check("part_busy", 32'(busy_o), 32'd1);
      snes_clk = 1'b0;
      cycles(6);
      read_frame(16, -1, 12'h000, rd);
      check("relatch_frame", 32'(rd), 32'hFF0C);
      check("relatch_done_cnt", 32'(done_cnt - d0), 32'd1);

      // Buttons changing mid-SHIFT do not affect the current frame
      buttons = 12'h000;
      read_frame(16, 3, 12'hFFF, rd);
      check("chg_cur_frame", 32'(rd), 32'hFFFF);
      read_frame(16, -1, 12'h000, rd);
      check("chg_next_frame", 32'(rd), 32'hF000);

      // Stall the serial clock after 3 bits
      buttons = 12'h000;
      d0 = done_cnt;
      read_frame(3, -1, 12'h000, rd);
`ifdef SNES_PAD_WATCHDOG_EN
      waited = 12;
      while (wdog_cnt == 0 && waited < 300) begin
         cycles(1);
         waited++;
      end
      check("wdog_seen", 32'(wdog_cnt), 32'd1);
      check("wdog_window", 32'(waited >= 60 && waited <= 75), 32'd1);
      cycles(2);
      check("wdog_ser", 32'(ser_data_o), 32'd1);
      check("wdog_busy", 32'(busy_o), 32'd0);
`else
      waited = 0;
      cycles(200);
      check("stall_busy", 32'(busy_o), 32'd1);
      check("stall_wdog", 32'(wdog_cnt), 32'd0);
      check("stall_ser", 32'(ser_data_o), 32'd1);
`endif
      check("stall_no_done", 32'(done_cnt - d0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
